// File: rtl/submit_queue_if.sv
// Rename-side, consumer-side and writeback signal bundle for submit_queue.
interface submit_queue_if #(
    parameter int IN_WIDTH  = 3,
    parameter int OUT_WIDTH = 2,
    parameter int DEPTH     = 8,
    parameter int WB_WIDTH  = 2,
    parameter int FU_OP_W   = 4,
    parameter int FU_SEL_W  = 3,
    parameter int PC_W      = 32,
    parameter int IMM_W     = 32,
    parameter int PREG_W    = 7
);
    logic [IN_WIDTH-1:0]                   in_valid;
    logic [IN_WIDTH-1:0][FU_OP_W-1:0]      in_fu_op;
    logic [IN_WIDTH-1:0][FU_SEL_W-1:0]     in_fu_sel;
    logic [IN_WIDTH-1:0][PC_W-1:0]         in_pc;
    logic [IN_WIDTH-1:0][IMM_W-1:0]        in_imm;
    logic [IN_WIDTH-1:0][1:0][PREG_W-1:0]  in_src;
    logic [IN_WIDTH-1:0][1:0]              in_src_ready;
    logic [IN_WIDTH-1:0][PREG_W-1:0]       in_dst;
    logic [IN_WIDTH-1:0][PREG_W-1:0]       in_dst_old;
    logic                                  in_ready;

    logic [OUT_WIDTH-1:0]                  out_valid;
    logic [OUT_WIDTH-1:0][FU_OP_W-1:0]     out_fu_op;
    logic [OUT_WIDTH-1:0][FU_SEL_W-1:0]    out_fu_sel;
    logic [OUT_WIDTH-1:0][PC_W-1:0]        out_pc;
    logic [OUT_WIDTH-1:0][IMM_W-1:0]       out_imm;
    logic [OUT_WIDTH-1:0][1:0][PREG_W-1:0] out_src;
    logic [OUT_WIDTH-1:0][1:0]             out_src_ready;
    logic [OUT_WIDTH-1:0][PREG_W-1:0]      out_dst;
    logic [OUT_WIDTH-1:0][PREG_W-1:0]      out_dst_old;
    logic [$clog2(OUT_WIDTH+1)-1:0]        out_take;

    logic [WB_WIDTH-1:0]                   wb_valid;
    logic [WB_WIDTH-1:0][PREG_W-1:0]       wb_tag;

    logic [$clog2(DEPTH+1)-1:0]            count;

    modport master (
        output in_valid, in_fu_op, in_fu_sel, in_pc, in_imm, in_src, in_src_ready,
               in_dst, in_dst_old, out_take, wb_valid, wb_tag,
        input  in_ready, out_valid, out_fu_op, out_fu_sel, out_pc, out_imm, out_src,
               out_src_ready, out_dst, out_dst_old, count
    );

    modport slave (
        input  in_valid, in_fu_op, in_fu_sel, in_pc, in_imm, in_src, in_src_ready,
               in_dst, in_dst_old, out_take, wb_valid, wb_tag,
        output in_ready, out_valid, out_fu_op, out_fu_sel, out_pc, out_imm, out_src,
               out_src_ready, out_dst, out_dst_old, count
    );
endinterface

// File: rtl/submit_queue.sv
// In-order dispatch buffer between rename and ROB/issue with writeback wakeup and flush.
// Define SUBMIT_QUEUE_STATS_EN to add the stat_peak / stat_stall occupancy statistics.
module submit_queue #(
    parameter int IN_WIDTH  = 3,
    parameter int OUT_WIDTH = 2,
    parameter int DEPTH     = 8,
    parameter int WB_WIDTH  = 2,
    parameter int FU_OP_W   = 4,
    parameter int FU_SEL_W  = 3,
    parameter int PC_W      = 32,
    parameter int IMM_W     = 32,
    parameter int PREG_W    = 7
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    submit_queue_if.slave bus
`ifdef SUBMIT_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] stat_peak,
    output logic [31:0]                stat_stall
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    logic [DEPTH-1:0][FU_OP_W-1:0]     mem_fu_op;
    logic [DEPTH-1:0][FU_SEL_W-1:0]    mem_fu_sel;
    logic [DEPTH-1:0][PC_W-1:0]        mem_pc;
    logic [DEPTH-1:0][IMM_W-1:0]       mem_imm;
    logic [DEPTH-1:0][1:0][PREG_W-1:0] mem_src;
    logic [DEPTH-1:0][1:0]             mem_rdy;
    logic [DEPTH-1:0][PREG_W-1:0]      mem_dst;
    logic [DEPTH-1:0][PREG_W-1:0]      mem_dst_old;

    logic                         in_ready, enq_fire;
    logic [CW-1:0]                enq_n, deq_n;
    logic [IN_WIDTH-1:0][PW-1:0]  enq_slot;
    logic [IN_WIDTH-1:0][1:0]     enq_rdy;
    logic [OUT_WIDTH-1:0][PW-1:0] rd_idx;
    logic [OUT_WIDTH-1:0]         rd_v;

    function automatic logic wb_hit(input logic [PREG_W-1:0]               tag,
                                    input logic [WB_WIDTH-1:0]             v,
                                    input logic [WB_WIDTH-1:0][PREG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_WIDTH; k++) begin
            hit = hit | (v[k] && (t[k] == tag));
        end
        return hit;
    endfunction

    // Admission only looks at registered occupancy, never at a same-cycle dequeue.
    assign in_ready = (count <= CW'(DEPTH - IN_WIDTH));
    assign enq_fire = in_ready && (|bus.in_valid);
    assign deq_n    = (CW'(bus.out_take) > count) ? count : CW'(bus.out_take);

    // Valid lanes are packed in ascending lane order starting at tail.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            enq_slot[i]   = tail + PW'(enq_n);
            enq_rdy[i][0] = bus.in_src_ready[i][0] | wb_hit(bus.in_src[i][0], bus.wb_valid, bus.wb_tag);
            enq_rdy[i][1] = bus.in_src_ready[i][1] | wb_hit(bus.in_src[i][1], bus.wb_valid, bus.wb_tag);
            enq_n         = enq_n + CW'(bus.in_valid[i]);
        end
        if (!enq_fire) begin
            enq_n = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

    // Wakeup first, then fresh enqueues overwrite their own slots.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_rdy <= '0;
        end else if (flush) begin
            mem_rdy <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int s = 0; s < 2; s++) begin
                    if (wb_hit(mem_src[e][s], bus.wb_valid, bus.wb_tag)) begin
                        mem_rdy[e][s] <= 1'b1;
                    end
                end
            end
            if (enq_fire) begin
                for (int i = 0; i < IN_WIDTH; i++) begin
                    if (bus.in_valid[i]) begin
                        mem_rdy[enq_slot[i]] <= enq_rdy[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enq_fire) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (bus.in_valid[i]) begin
                    mem_fu_op[enq_slot[i]]   <= bus.in_fu_op[i];
                    mem_fu_sel[enq_slot[i]]  <= bus.in_fu_sel[i];
                    mem_pc[enq_slot[i]]      <= bus.in_pc[i];
                    mem_imm[enq_slot[i]]     <= bus.in_imm[i];
                    mem_src[enq_slot[i]]     <= bus.in_src[i];
                    mem_dst[enq_slot[i]]     <= bus.in_dst[i];
                    mem_dst_old[enq_slot[i]] <= bus.in_dst_old[i];
                end
            end
        end
    end

    // Unoccupied lanes are forced to zero so the bus is clean after reset and flush.
    always_comb begin
        for (int j = 0; j < OUT_WIDTH; j++) begin
            rd_idx[j]            = head + PW'(j);
            rd_v[j]              = (CW'(j) < count);
            bus.out_valid[j]     = rd_v[j];
            bus.out_fu_op[j]     = rd_v[j] ? mem_fu_op[rd_idx[j]]   : '0;
            bus.out_fu_sel[j]    = rd_v[j] ? mem_fu_sel[rd_idx[j]]  : '0;
            bus.out_pc[j]        = rd_v[j] ? mem_pc[rd_idx[j]]      : '0;
            bus.out_imm[j]       = rd_v[j] ? mem_imm[rd_idx[j]]     : '0;
            bus.out_src[j]       = rd_v[j] ? mem_src[rd_idx[j]]     : '0;
            bus.out_src_ready[j] = rd_v[j] ? mem_rdy[rd_idx[j]]     : '0;
            bus.out_dst[j]       = rd_v[j] ? mem_dst[rd_idx[j]]     : '0;
            bus.out_dst_old[j]   = rd_v[j] ? mem_dst_old[rd_idx[j]] : '0;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.count    = count;

    a_take_legal: assert property (@(posedge clock) disable iff (!reset_n)
                                   CW'(bus.out_take) <= count);

`ifdef SUBMIT_QUEUE_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_peak  <= '0;
            stat_stall <= '0;
        end else begin
            if (count > stat_peak) begin
                stat_peak <= count;
            end
            if ((|bus.in_valid) && !in_ready && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_submit_queue.sv
// Randomised and directed bench for submit_queue against a queue-based reference model.
module tb_submit_queue;
    localparam int IW = 3;
    localparam int OW = 2;
    localparam int D  = 8;
    localparam int WB = 2;
    localparam int NSTREAM = 40;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  sel;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  src0, src1;
        logic        r0, r1;
        logic [6:0]  dst, dold;
    } ent_t;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;
`ifdef SUBMIT_QUEUE_STATS_EN
    logic [3:0]  stat_peak;
    logic [31:0] stat_stall;
    logic [31:0] stall_base;
`endif

    submit_queue_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D), .WB_WIDTH(WB)) bus ();

    submit_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D), .WB_WIDTH(WB)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .flush  (flush),
        .bus    (bus)
`ifdef SUBMIT_QUEUE_STATS_EN
        ,
        .stat_peak (stat_peak),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    ent_t mq[$];
    logic [31:0] got[$];
    bit cmp_en = 1'b0;
    bit stream_on = 1'b0;
    int m_n, c_n, m_peak, m_stall;
    bit m_acc;
    ent_t m_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input logic [6:0] tag);
        bit h = 1'b0;
        for (int k = 0; k < WB; k++) begin
            if (bus.wb_valid[k] && bus.wb_tag[k] == tag) h = 1'b1;
        end
        return h;
    endfunction

    // Reference model: plain FIFO of entries updated once per rising edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_peak  = 0;
            m_stall = 0;
        end else begin
            m_n   = mq.size();
            m_acc = (D - m_n) >= IW;
            if (m_n > m_peak) m_peak = m_n;
            if ((|bus.in_valid) && !m_acc) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                for (int e = 0; e < mq.size(); e++) begin
                    if (m_hit(mq[e].src0)) mq[e].r0 = 1'b1;
                    if (m_hit(mq[e].src1)) mq[e].r1 = 1'b1;
                end
                for (int t = 0; t < int'(bus.out_take) && mq.size() > 0; t++) void'(mq.pop_front());
                if (m_acc) begin
                    for (int i = 0; i < IW; i++) begin
                        if (bus.in_valid[i]) begin
                            m_e.op   = bus.in_fu_op[i];
                            m_e.sel  = bus.in_fu_sel[i];
                            m_e.pc   = bus.in_pc[i];
                            m_e.imm  = bus.in_imm[i];
                            m_e.src0 = bus.in_src[i][0];
                            m_e.src1 = bus.in_src[i][1];
                            m_e.r0   = bus.in_src_ready[i][0] | m_hit(bus.in_src[i][0]);
                            m_e.r1   = bus.in_src_ready[i][1] | m_hit(bus.in_src[i][1]);
                            m_e.dst  = bus.in_dst[i];
                            m_e.dold = bus.in_dst_old[i];
                            mq.push_back(m_e);
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            c_n = mq.size();
            chk("count", 64'(bus.count), 64'(c_n));
            chk("in_ready", 64'(bus.in_ready), 64'((D - c_n) >= IW));
            for (int j = 0; j < OW; j++) begin
                chk("out_valid", 64'(bus.out_valid[j]), 64'(j < c_n));
                if (j < c_n) begin
                    chk("out_pc",        64'(bus.out_pc[j]),        64'(mq[j].pc));
                    chk("out_fu_op",     64'(bus.out_fu_op[j]),     64'(mq[j].op));
                    chk("out_fu_sel",    64'(bus.out_fu_sel[j]),    64'(mq[j].sel));
                    chk("out_imm",       64'(bus.out_imm[j]),       64'(mq[j].imm));
                    chk("out_src",       64'(bus.out_src[j]),       64'({mq[j].src1, mq[j].src0}));
                    chk("out_src_ready", 64'(bus.out_src_ready[j]), 64'({mq[j].r1, mq[j].r0}));
                    chk("out_dst",       64'(bus.out_dst[j]),       64'(mq[j].dst));
                    chk("out_dst_old",   64'(bus.out_dst_old[j]),   64'(mq[j].dold));
                end
            end
`ifdef SUBMIT_QUEUE_STATS_EN
            chk("stat_peak",  64'(stat_peak),  64'(m_peak));
            chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
            if (stream_on) begin
                for (int j = 0; j < int'(bus.out_take) && j < OW; j++) got.push_back(bus.out_pc[j]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = '0;
        bus.out_take = '0;
        bus.wb_valid = '0;
        bus.wb_tag   = '0;
        flush        = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [6:0] s0,
                            input logic r0, input logic [6:0] s1, input logic r1);
        bus.in_valid[i]        = 1'b1;
        bus.in_pc[i]           = pc;
        bus.in_fu_op[i]        = 4'($urandom);
        bus.in_fu_sel[i]       = 3'($urandom);
        bus.in_imm[i]          = $urandom;
        bus.in_src[i][0]       = s0;
        bus.in_src[i][1]       = s1;
        bus.in_src_ready[i][0] = r0;
        bus.in_src_ready[i][1] = r1;
        bus.in_dst[i]          = 7'($urandom);
        bus.in_dst_old[i]      = 7'($urandom);
    endtask

    task automatic fill_all(input logic [31:0] base);
        for (int i = 0; i < IW; i++) set_lane(i, base + 32'(4 * i), 7'd1, 1'b0, 7'd2, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int sent, cyc, take_max;
        bit pending, done;
        logic [2:0] v;

        reset_n = 1'b0;
        idle();
        bus.in_fu_op = '0; bus.in_fu_sel = '0; bus.in_pc = '0; bus.in_imm = '0;
        bus.in_src = '0; bus.in_src_ready = '0; bus.in_dst = '0; bus.in_dst_old = '0;
        cmp_en = 1'b1;
        tick();
        tick();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        reset_n = 1'b1;
        tick();

        // Non-contiguous lanes compact into consecutive slots.
        set_lane(0, 32'h100, 7'd1, 1'b0, 7'd2, 1'b0);
        set_lane(2, 32'h108, 7'd3, 1'b0, 7'd4, 1'b0);
        bus.in_pc[1] = 32'h104;
        tick();
        idle();
        chk("t1_count", 64'(bus.count), 64'd2);
        chk("t1_out_valid", 64'(bus.out_valid), 64'b11);
        chk("t1_out_pc0", 64'(bus.out_pc[0]), 64'h100);
        chk("t1_out_pc1", 64'(bus.out_pc[1]), 64'h108);
        bus.out_take = 2'd2;
        tick();
        idle();

        // Two full groups, then a dequeue that reopens admission.
        fill_all(32'h200);
        tick();
        fill_all(32'h300);
        tick();
        idle();
        chk("t2_count6", 64'(bus.count), 64'd6);
        chk("t2_in_ready0", 64'(bus.in_ready), 64'd0);
        bus.out_take = 2'd2;
        tick();
        idle();
        chk("t2_count4", 64'(bus.count), 64'd4);
        chk("t2_in_ready1", 64'(bus.in_ready), 64'd1);
        bus.out_take = 2'd2;
        tick();
        tick();
        idle();

        // Wakeup of a stored entry and of a same-cycle enqueue.
        set_lane(0, 32'h400, 7'd17, 1'b0, 7'd3, 1'b0);
        tick();
        idle();
        chk("wk_before", 64'(bus.out_src_ready[0][0]), 64'd0);
        set_lane(0, 32'h404, 7'd17, 1'b0, 7'd5, 1'b0);
        bus.wb_valid  = 2'b10;
        bus.wb_tag[1] = 7'd17;
        tick();
        idle();
        chk("wk_stored", 64'(bus.out_src_ready[0][0]), 64'd1);
        chk("wk_enq", 64'(bus.out_src_ready[1][0]), 64'd1);
        chk("wk_other", 64'(bus.out_src_ready[0][1]), 64'd0);
        bus.out_take = 2'd2;
        tick();
        idle();

        // Flush wins over a concurrent enqueue and dequeue.
        fill_all(32'h500);
        tick();
        idle();
        set_lane(0, 32'h50c, 7'd6, 1'b0, 7'd7, 1'b0);
        set_lane(1, 32'h510, 7'd8, 1'b0, 7'd9, 1'b0);
        tick();
        idle();
        chk("fl_count5", 64'(bus.count), 64'd5);
        fill_all(32'h600);
        bus.out_take = 2'd2;
        flush = 1'b1;
        tick();
        idle();
        chk("fl_count", 64'(bus.count), 64'd0);
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);

        // Random stream with producer hold; dequeued pcs must be strictly sequential.
        sent = 0;
        pending = 1'b0;
        done = 1'b0;
        stream_on = 1'b1;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (sent == NSTREAM && mq.size() == 0 && !pending) begin
                done = 1'b1;
                break;
            end
            if (!pending) begin
                bus.in_valid = '0;
                v = 3'($urandom_range(0, 7));
                for (int i = 0; i < IW; i++) begin
                    if (v[i] && sent < NSTREAM) begin
                        set_lane(i, 32'h1000 + 32'(4 * sent), 7'($urandom_range(0, 15)), 1'($urandom),
                                 7'($urandom_range(0, 15)), 1'($urandom));
                        sent++;
                    end
                end
            end
            take_max = (mq.size() < OW) ? mq.size() : OW;
            bus.out_take = 2'($urandom_range(0, take_max));
            bus.wb_valid = 2'($urandom);
            bus.wb_tag[0] = 7'($urandom_range(0, 15));
            bus.wb_tag[1] = 7'($urandom_range(0, 15));
            pending = (|bus.in_valid) && !((D - mq.size()) >= IW);
            tick();
        end
        stream_on = 1'b0;
        idle();
        chk("stream_done", 64'(done), 64'd1);
        chk("stream_len", 64'(got.size()), 64'(NSTREAM));
        for (int k = 0; k < got.size(); k++) chk("stream_order", 64'(got[k]), 64'(32'h1000 + 32'(4 * k)));

        // Fill to full, stall four cycles, then drain.
`ifdef SUBMIT_QUEUE_STATS_EN
        stall_base = stat_stall;
`endif
        fill_all(32'h700);
        tick();
        idle();
        set_lane(0, 32'h70c, 7'd10, 1'b0, 7'd11, 1'b0);
        set_lane(1, 32'h710, 7'd12, 1'b0, 7'd13, 1'b0);
        tick();
        fill_all(32'h714);
        tick();
        chk("full_count", 64'(bus.count), 64'd8);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_out_valid", 64'(bus.out_valid), 64'b11);
        for (int s = 0; s < 4; s++) tick();
        idle();
        for (int s = 0; s < 4; s++) begin
            bus.out_take = 2'd2;
            tick();
        end
        idle();
        chk("drain_count", 64'(bus.count), 64'd0);
`ifdef SUBMIT_QUEUE_STATS_EN
        chk("stat_peak_lit", 64'(stat_peak), 64'd8);
        chk("stat_stall_delta", 64'(stat_stall - stall_base), 64'd4);
`endif
        tick();
        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/submit_queue.md
Name: submit_queue

Overview:
- Parametrised dispatch buffer between rename (map table) and the ROB/issue side.
- Accepts up to IN_WIDTH renamed instructions per cycle and presents up to OUT_WIDTH oldest entries per cycle, in program order.
- Tracks operand readiness via writeback-tag wakeup while entries wait.
- Successor to the fixed-width, unbuffered submit bundle: adds depth, decoupled in/out widths, flow control, wakeup and flush.

Parameters:
- IN_WIDTH, 3, rename lanes per cycle.
- OUT_WIDTH, 2, entries presented to the consumer per cycle; must be <= DEPTH.
- DEPTH, 8, storage entries; power of two, >= IN_WIDTH.
- WB_WIDTH, 2, writeback tag broadcast ports.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  discard all contents.
- in_valid  input  IN_WIDTH  per-lane valid; lanes need not be contiguous.
- in_fu_op / in_fu_sel / in_pc / in_imm  input  IN_WIDTH x fu_op_t / fu_sel_t / pc_t / imm_t  instruction fields.
- in_src  input  IN_WIDTH x 2 x phy_reg_t  source physical registers.
- in_src_ready  input  IN_WIDTH x 2  source ready at rename.
- in_dst / in_dst_old  input  IN_WIDTH x phy_reg_t  new and previous destination mapping.
- in_ready  output  1  queue accepts a full IN_WIDTH group this cycle.
- out_valid  output  OUT_WIDTH  out_valid[i] = (i < count).
- out_fu_op / out_fu_sel / out_pc / out_imm / out_src / out_src_ready / out_dst / out_dst_old  output  OUT_WIDTH x (field types as above)  head entries, oldest at lane 0.
- out_take  input  $clog2(OUT_WIDTH+1)  number of head entries consumed this cycle (prefix).
- wb_valid  input  WB_WIDTH  writeback broadcast valid.
- wb_tag  input  WB_WIDTH x phy_reg_t  writeback destination tag.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset_n low, async): head = 0, tail = 0, count = 0, all stored src_ready bits = 0. Outputs: out_valid = 0, in_ready = 1, out_* data = 0. Deassertion is synchronised externally.
- Storage: circular buffer. head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- in_ready:
  - Combinational from registered count only: (DEPTH - count) >= IN_WIDTH.
  - No credit is given for a same-cycle dequeue.
- Enqueue:
  - Occurs when in_ready && |in_valid.
  - Valid lanes are compacted in ascending lane order into tail, tail+1, ...
  - tail advances by popcount(in_valid).
  - If in_ready = 0, inputs are ignored; the producer must hold them.
- Stored ready bit = in_src_ready | (any wb_valid[k] && wb_tag[k] == in_src) in the same cycle. A same-cycle writeback is never lost.
- Output path:
  - out_* is purely combinational from entries head .. head+OUT_WIDTH-1 (mod DEPTH); lanes >= count carry don't-care data.
  - Zero-latency read; an entry is visible the cycle after enqueue.
- Dequeue:
  - head advances by out_take.
  - out_take > count is a protocol error: simulation assertion fires, and the value is clamped to count.
- count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue are supported in the same cycle.
- Wakeup:
  - Each cycle, every occupied entry and each src slot with wb_valid[k] && wb_tag[k] == src sets its ready bit at the next edge.
  - out_src_ready shows the registered value: wakeup is visible 1 cycle later.
  - Ready bits never clear while the entry is occupied.
- flush:
  - Highest priority. Next cycle: head = tail = count = 0 and ready bits cleared.
  - Same-cycle enqueue, dequeue and wakeup are discarded.
- Full (count = DEPTH): in_ready = 0, out_valid all ones.
- Empty: out_valid = 0, and out_take must be 0.

Optional Feature:
- Macro: SUBMIT_QUEUE_STATS_EN.
- Defined: adds two outputs, both reset to 0 and cleared by neither flush nor dequeue:
  - stat_peak  $clog2(DEPTH+1)  highest count seen since reset.
  - stat_stall  32  cycles with |in_valid && !in_ready; saturates at all ones.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid = 3'b101 with pc 0x100 (lane 0) and 0x108 (lane 2) -> next cycle count = 2, out_valid = 2'b11, out_pc[0] = 0x100, out_pc[1] = 0x108.
- Two full enqueues of 3 with out_take = 0 -> count = 6, in_ready = 0. Then out_take = 2 -> count = 4, in_ready = 1.
- Stream 40 instructions with incrementing pc, random in_valid and random legal out_take -> dequeue order equals enqueue order across pointer wrap; count never exceeds 8.
- Stored entry with src[0] = 17, ready 0; drive wb_valid[1] = 1, wb_tag[1] = 17 -> next cycle out_src_ready[0][0] = 1. A lane enqueued in the same cycle with src 17, ready 0 is stored with ready 1.
- count = 5, assert flush together with enqueue of 3 and out_take = 2 -> next cycle count = 0, out_valid = 0, in_ready = 1.
- With SUBMIT_QUEUE_STATS_EN: fill to 8, stall 4 cycles with all in_valid high, then drain -> stat_peak = 8, stat_stall = 4.
